// File: rtl/t2mi_packet_scheduler_if.sv
// -----------------------------------------------------------------------------
// t2mi_packet_scheduler_if
// Handshake and header bundle between the T2-MI packet scheduler and the
// packetizer that serialises each packet.
//   pkt_start      : scheduler -> packetizer, one-cycle request for one packet
//   pkt_done       : packetizer -> scheduler, one-cycle pulse once CRC-32 is out
//   pkt_type       : 0 = BB frame, 1 = timestamp, 2 = L1
//   packet_count, frame_idx, superframe_idx, bb_frame_count, subseconds :
//                    header fields of the packet in flight
//   ifs            : interleaving-frame-start flag
// Modports: master = scheduler side, slave = packetizer side.
// -----------------------------------------------------------------------------
interface t2mi_packet_scheduler_if;
  logic        pkt_start;
  logic        pkt_done;
  logic [1:0]  pkt_type;
  logic [7:0]  packet_count;
  logic [7:0]  frame_idx;
  logic [3:0]  superframe_idx;
  logic [9:0]  bb_frame_count;
  logic [26:0] subseconds;
  logic        ifs;

  modport master (
    output pkt_start, pkt_type, packet_count, frame_idx, superframe_idx,
           bb_frame_count, subseconds, ifs,
    input  pkt_done
  );

  modport slave (
    input  pkt_start, pkt_type, packet_count, frame_idx, superframe_idx,
           bb_frame_count, subseconds, ifs,
    output pkt_done
  );
endinterface

// File: rtl/t2mi_packet_scheduler.sv
// -----------------------------------------------------------------------------
// t2mi_packet_scheduler
// Sequences T2-MI packet requests: BB frames of one interleaving frame, an
// optional timestamp packet, then the L1 packet, and keeps the header counters
// (packet, frame, superframe, BB frame, subseconds) for each packet.
//
// Ports
//   i_clk            : single clock, rising edge
//   i_rst_n          : synchronous active-low reset
//   i_enable         : permits sequencing (TS sync found)
//   i_plp_num_blocks : BB frames per interleaving frame (0 treated as 1)
//   i_num_t2_frames  : T2 frames per superframe (0 treated as 1)
//   i_t_sf_ssu       : superframe duration in subsecond units
//   pkt_if           : packetizer handshake + header fields (master side)
//   o_busy           : high in ISSUE, WAIT_DONE, ADVANCE
//   o_err            : high in ERROR (packetizer watchdog expired)
//   o_state_mon      : encoded state
//
// Build option: define T2MI_TIMESTAMP_EN to insert the timestamp packet between
// the last BB frame and the L1 packet and to advance subseconds per superframe.
// Without it the timestamp step is skipped and subseconds stays 0.
//
// States
//   IDLE      (0) | waiting for i_enable; sequence position retained
//   ISSUE     (1) | pkt_start high for this single cycle
//   WAIT_DONE (2) | waiting for pkt_done; watchdog running
//   ADVANCE   (3) | step the header counters to the next packet
//   ERROR     (4) | watchdog expired; leave when i_enable drops
// -----------------------------------------------------------------------------
module t2mi_packet_scheduler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_enable,
  input  logic [9:0]                      i_plp_num_blocks,
  input  logic [7:0]                      i_num_t2_frames,
  input  logic [26:0]                     i_t_sf_ssu,
  t2mi_packet_scheduler_if.master         pkt_if,
  output logic                            o_busy,
  output logic                            o_err,
  output logic [2:0]                      o_state_mon
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_ADVANCE   = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  localparam logic [1:0] TYPE_BB = 2'd0;
  localparam logic [1:0] TYPE_TS = 2'd1;
  localparam logic [1:0] TYPE_L1 = 2'd2;

  // Down-counter loaded on ISSUE; WAIT_DONE lasts TIMEOUT_CYCLES cycles before
  // the terminal count sends the FSM to ERROR.
  localparam logic [15:0] WDOG_LOAD = (TIMEOUT_CYCLES == 16'd0) ? 16'd0
                                                                : TIMEOUT_CYCLES - 16'd1;

  state_t      r_state;
  logic        r_pkt_start;
  logic        r_busy;
  logic        r_err;
  logic [1:0]  r_pkt_type;
  logic [7:0]  r_packet_count;
  logic [7:0]  r_frame_idx;
  logic [3:0]  r_superframe_idx;
  logic [9:0]  r_bb_frame_count;
  logic [26:0] r_subseconds;
  logic [15:0] r_wdog;
  logic [9:0]  r_nb;
  logic [7:0]  r_nf;

  logic        w_last_bb;
  logic        w_last_frame;
  logic        w_group_start;
  logic [1:0]  w_type_after_bb;
  logic [26:0] w_ssu_next;

  // >= rather than == keeps the sequence bounded if a counter ever exceeds the
  // latched limit.
  assign w_last_bb     = (r_bb_frame_count >= (r_nb - 10'd1));
  assign w_last_frame  = (r_frame_idx >= (r_nf - 8'd1));
  assign w_group_start = (r_pkt_type == TYPE_BB) && (r_bb_frame_count == 10'd0);

`ifdef T2MI_TIMESTAMP_EN
  assign w_type_after_bb = TYPE_TS;
  assign w_ssu_next      = r_subseconds + i_t_sf_ssu;
`else
  logic w_unused_tsf;
  assign w_type_after_bb = TYPE_L1;
  assign w_ssu_next      = r_subseconds;
  assign w_unused_tsf    = ^i_t_sf_ssu;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_pkt_start      <= 1'b0;
      r_busy           <= 1'b0;
      r_err            <= 1'b0;
      r_pkt_type       <= TYPE_BB;
      r_packet_count   <= 8'd0;
      r_frame_idx      <= 8'd0;
      r_superframe_idx <= 4'd0;
      r_bb_frame_count <= 10'd0;
      r_subseconds     <= 27'd0;
      r_wdog           <= 16'd0;
      r_nb             <= 10'd1;
      r_nf             <= 8'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state     <= S_ISSUE;
            r_pkt_start <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_ISSUE: begin
          r_state     <= S_WAIT_DONE;
          r_pkt_start <= 1'b0;
          r_wdog      <= WDOG_LOAD;
          // Group geometry is frozen for the whole interleaving frame.
          if (w_group_start) begin
            r_nb <= (i_plp_num_blocks == 10'd0) ? 10'd1 : i_plp_num_blocks;
            r_nf <= (i_num_t2_frames == 8'd0) ? 8'd1 : i_num_t2_frames;
          end
        end

        S_WAIT_DONE: begin
          if (pkt_if.pkt_done) begin
            r_state <= S_ADVANCE;
          end else if (r_wdog == 16'd0) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_wdog <= r_wdog - 16'd1;
          end
        end

        S_ADVANCE: begin
          r_packet_count <= r_packet_count + 8'd1;
          case (r_pkt_type)
            TYPE_BB: begin
              if (w_last_bb) begin
                r_bb_frame_count <= 10'd0;
                r_pkt_type       <= w_type_after_bb;
              end else begin
                r_bb_frame_count <= r_bb_frame_count + 10'd1;
              end
            end
            TYPE_TS: r_pkt_type <= TYPE_L1;
            TYPE_L1: begin
              r_pkt_type <= TYPE_BB;
              if (w_last_frame) begin
                r_frame_idx      <= 8'd0;
                r_superframe_idx <= r_superframe_idx + 4'd1;
                r_subseconds     <= w_ssu_next;
              end else begin
                r_frame_idx <= r_frame_idx + 8'd1;
              end
            end
            default: r_pkt_type <= TYPE_BB;
          endcase
          if (i_enable) begin
            r_state     <= S_ISSUE;
            r_pkt_start <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_ERROR: begin
          if (!i_enable) begin
            r_state          <= S_IDLE;
            r_err            <= 1'b0;
            r_pkt_type       <= TYPE_BB;
            r_bb_frame_count <= 10'd0;
            r_frame_idx      <= 8'd0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_pkt_start <= 1'b0;
          r_busy      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  assign pkt_if.pkt_start      = r_pkt_start;
  assign pkt_if.pkt_type       = r_pkt_type;
  assign pkt_if.packet_count   = r_packet_count;
  assign pkt_if.frame_idx      = r_frame_idx;
  assign pkt_if.superframe_idx = r_superframe_idx;
  assign pkt_if.bb_frame_count = r_bb_frame_count;
  assign pkt_if.subseconds     = r_subseconds;
  assign pkt_if.ifs            = w_group_start;

  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_state_mon = r_state;

endmodule
